// File: rtl/delivery_velocity_ctrl_if.sv
// Signal bundle between the velocity sequencer, the game control unit and
// the echo-measurement datapath. The controller side takes the slave modport.
interface delivery_velocity_ctrl_if #(
   parameter int DIST_W = 12
);
   logic              get_velocity;
   logic              meas_done;
   logic [DIST_W-1:0] meas_dist;
   logic              meas_reset;
   logic              meas_start;
   logic [1:0]        velocity;
   logic              velocity_ready;
   logic              timeout_err;
   logic [3:0]        estado;

   // Requester and measurement datapath side.
   modport master (
      output get_velocity, meas_done, meas_dist,
      input  meas_reset, meas_start, velocity, velocity_ready, timeout_err, estado
   );

   // Velocity sequencer side.
   modport slave (
      input  get_velocity, meas_done, meas_dist,
      output meas_reset, meas_start, velocity, velocity_ready, timeout_err, estado
   );
endinterface

// File: rtl/delivery_velocity_ctrl.sv
// Velocity sequencer: on each request it runs 2^SAMPLES_LOG2 trigger/echo
// measurements, averages the distances and classifies the average into a
// 2-bit velocity level, then pulses velocity_ready for one cycle.
module delivery_velocity_ctrl #(
   parameter int DIST_W         = 12,
   parameter int SAMPLES_LOG2   = 2,
   parameter int TRIG_CYCLES    = 500,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int TH1            = 100,
   parameter int TH2            = 200,
   parameter int TH3            = 300
) (
   input logic                   clock,
   input logic                   reset,
   delivery_velocity_ctrl_if.slave bus
);

   localparam int ACC_W   = DIST_W + SAMPLES_LOG2;
   localparam int CNT_MAX = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SCNT_W  = SAMPLES_LOG2 + 1;

   localparam logic [CNT_W-1:0]  TRIG_LAST      = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SCNT_W-1:0] NUM_SAMPLES    = SCNT_W'(1 << SAMPLES_LOG2);
   localparam logic [DIST_W-1:0] SAMPLE_TIMEOUT = '1;
   localparam logic [ACC_W-1:0]  TH1_V          = ACC_W'(TH1);
   localparam logic [ACC_W-1:0]  TH2_V          = ACC_W'(TH2);
   localparam logic [ACC_W-1:0]  TH3_V          = ACC_W'(TH3);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CLEAR     = 4'd1,
      S_TRIGGER   = 4'd2,
      S_WAIT_ECHO = 4'd3,
      S_ACCUM     = 4'd4,
      S_CLASSIFY  = 4'd5,
      S_READY     = 4'd6
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;
   logic [SCNT_W-1:0]   scnt_inc;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    avg;
   logic [DIST_W-1:0]   sample_q, sample_d;
   logic [1:0]          velocity_q, velocity_d;
   logic                timeout_err_q, timeout_err_d;
   logic                meas_reset_q, meas_reset_d;
   logic                meas_start_q, meas_start_d;
   logic                velocity_ready_q, velocity_ready_d;

   // Next-state and datapath decode for the measurement sequence.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it
      // unassigned; otherwise a latch would be inferred.
      state_d       = state_q;
      cnt_d         = cnt_q;
      scnt_d        = scnt_q;
      acc_d         = acc_q;
      sample_d      = sample_q;
      velocity_d    = velocity_q;
      timeout_err_d = timeout_err_q;
      scnt_inc      = scnt_q + 1'b1;
      avg           = acc_q >> SAMPLES_LOG2;

      unique case (state_q)
         S_IDLE: begin
            if (bus.get_velocity) begin
               state_d       = S_CLEAR;
               acc_d         = '0;
               scnt_d        = '0;
               timeout_err_d = 1'b0;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_TRIGGER;
         end
         S_TRIGGER: begin
            if (cnt_q == TRIG_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT_ECHO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_ECHO: begin
            // A real echo has priority over a timeout expiring in the same cycle.
            if (bus.meas_done) begin
               sample_d = bus.meas_dist;
               state_d  = S_ACCUM;
            end else if (cnt_q == TIMEOUT_LAST) begin
               sample_d      = SAMPLE_TIMEOUT;
               timeout_err_d = 1'b1;
               state_d       = S_ACCUM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ACCUM: begin
            acc_d   = acc_q + ACC_W'(sample_q);
            scnt_d  = scnt_inc;
            state_d = (scnt_inc == NUM_SAMPLES) ? S_CLASSIFY : S_CLEAR;
         end
         S_CLASSIFY: begin
            if (avg < TH1_V)      velocity_d = 2'd3;
            else if (avg < TH2_V) velocity_d = 2'd2;
            else if (avg < TH3_V) velocity_d = 2'd1;
            else                  velocity_d = 2'd0;
            state_d = S_READY;
         end
         S_READY: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so the registered copies
      // line up exactly with the state they belong to.
      meas_reset_d     = (state_d == S_CLEAR);
      meas_start_d     = (state_d == S_TRIGGER);
      velocity_ready_d = (state_d == S_READY);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         scnt_q           <= '0;
         acc_q            <= '0;
         sample_q         <= '0;
         velocity_q       <= 2'd0;
         timeout_err_q    <= 1'b0;
         meas_reset_q     <= 1'b0;
         meas_start_q     <= 1'b0;
         velocity_ready_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         scnt_q           <= scnt_d;
         acc_q            <= acc_d;
         sample_q         <= sample_d;
         velocity_q       <= velocity_d;
         timeout_err_q    <= timeout_err_d;
         meas_reset_q     <= meas_reset_d;
         meas_start_q     <= meas_start_d;
         velocity_ready_q <= velocity_ready_d;
      end
   end

   assign bus.meas_reset     = meas_reset_q;
   assign bus.meas_start     = meas_start_q;
   assign bus.velocity       = velocity_q;
   assign bus.velocity_ready = velocity_ready_q;
   assign bus.timeout_err    = timeout_err_q;
   assign bus.estado         = state_q;

endmodule

// File: tb/tb_delivery_velocity_ctrl.sv
// Bench for delivery_velocity_ctrl. A timeline model predicts every output
// for every cycle from the request schedule; per-request literal values
// (latency, velocity, error flag, strobe counts) pin the model.
module tb_delivery_velocity_ctrl;

   localparam int DIST_W  = 12;
   localparam int SLOG2   = 1;
   localparam int TRIG    = 4;
   localparam int TO      = 20;
   localparam int TH1     = 100;
   localparam int TH2     = 200;
   localparam int TH3     = 300;
   localparam int MAXC    = 1000;
   localparam int ALLONES = (1 << DIST_W) - 1;

   logic clk;
   logic rst_n;
   int   cyc;

   delivery_velocity_ctrl_if #(.DIST_W(DIST_W)) bus ();

   delivery_velocity_ctrl #(
      .DIST_W(DIST_W), .SAMPLES_LOG2(SLOG2), .TRIG_CYCLES(TRIG),
      .TIMEOUT_CYCLES(TO), .TH1(TH1), .TH2(TH2), .TH3(TH3)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected per-cycle outputs.
   int exp_st  [MAXC];
   int exp_rst [MAXC];
   int exp_strt[MAXC];
   int exp_rdy [MAXC];
   int exp_vel [MAXC];
   int exp_terr[MAXC];
   int mvel;
   int mterr;

   int n_checks;
   int n_err;
   int start_cnt, reset_cnt, ready_cnt, last_ready_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic put(input int idx, input int st, input int rs, input int sr, input int rd);
      if (idx < MAXC) begin
         exp_st[idx]   = st;
         exp_rst[idx]  = rs;
         exp_strt[idx] = sr;
         exp_rdy[idx]  = rd;
         exp_vel[idx]  = mvel;
         exp_terr[idx] = mterr;
      end
   endtask

   task automatic fill_idle(input int from);
      for (int k = from; k < MAXC; k++) put(k, 0, 0, 0, 0);
   endtask

   // Lays out one request on the timeline starting with CLEAR at cycle a.
   // j is the WAIT_ECHO cycle (1-based) in which meas_done is given; 0 = never.
   task automatic model_request(input int a, input int d0, input int j0, input int d1,
                                input int j1, output int r, output int dc0, output int dc1);
      int b, acc, w, samp, j, d, dc, avg;
      b = a; acc = 0; mterr = 0; dc0 = -1; dc1 = -1;
      for (int s = 0; s < 2; s++) begin
         d = (s == 0) ? d0 : d1;
         j = (s == 0) ? j0 : j1;
         put(b, 1, 1, 0, 0); b++;
         for (int t = 0; t < TRIG; t++) begin put(b, 2, 0, 1, 0); b++; end
         if (j >= 1 && j <= TO) begin w = j; samp = d; dc = b + j - 1; end
         else begin w = TO; samp = ALLONES; dc = -1; end
         for (int t = 0; t < w; t++) begin put(b, 3, 0, 0, 0); b++; end
         if (dc < 0) mterr = 1;
         put(b, 4, 0, 0, 0); b++;
         acc += samp;
         if (s == 0) dc0 = dc; else dc1 = dc;
      end
      put(b, 5, 0, 0, 0); b++;
      avg  = acc / 2;
      mvel = (avg < TH1) ? 3 : (avg < TH2) ? 2 : (avg < TH3) ? 1 : 0;
      r    = b;
      put(b, 6, 0, 0, 1);
      fill_idle(b + 1);
   endtask

   // Every-cycle comparison against the timeline, plus strobe monitors.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (cyc < MAXC) begin
            check("meas_reset",     32'(bus.meas_reset),     32'(exp_rst[cyc]));
            check("meas_start",     32'(bus.meas_start),     32'(exp_strt[cyc]));
            check("velocity_ready", 32'(bus.velocity_ready), 32'(exp_rdy[cyc]));
            check("velocity",       32'(bus.velocity),       32'(exp_vel[cyc]));
            check("timeout_err",    32'(bus.timeout_err),    32'(exp_terr[cyc]));
            check("estado",         32'(bus.estado),         32'(exp_st[cyc]));
         end
         if (bus.meas_start) start_cnt++;
         if (bus.meas_reset) reset_cnt++;
         if (bus.velocity_ready) begin ready_cnt++; last_ready_cyc = cyc; end
      end
   end

   // Issues one request from an IDLE-cycle negedge and returns at the negedge
   // of the first IDLE cycle after READY (or after an aborting reset).
   task automatic do_request(input string tag, input int d0, input int j0, input int d1,
                             input int j1, input bit hold, input int abort_rel,
                             input int exp_lat, input int exp_v, input int exp_te);
      int n, a, r, dc0, dc1, s0, r0, y0;
      n = cyc; a = n + 1;
      bus.get_velocity = 1'b1;
      model_request(a, d0, j0, d1, j1, r, dc0, dc1);
      s0 = start_cnt; r0 = reset_cnt; y0 = ready_cnt;
      for (int c = n + 1; c <= r + 1; c++) begin
         @(negedge clk);
         if (!hold) bus.get_velocity = 1'b0;
         if (abort_rel >= 0 && c == a + abort_rel) begin
            rst_n = 1'b0;
            bus.meas_done = 1'b0;
            mvel = 0; mterr = 0;
            fill_idle(c);
            @(negedge clk);
            rst_n = 1'b1;
            check({tag, "_abort_ready"}, 32'(ready_cnt - y0), 32'd0);
            check({tag, "_abort_vel"},   32'(bus.velocity),   32'd0);
            check({tag, "_abort_state"}, 32'(bus.estado),     32'd0);
            return;
         end
         bus.meas_done = (c == dc0) || (c == dc1);
         bus.meas_dist = (c == dc0) ? DIST_W'(d0) : (c == dc1) ? DIST_W'(d1) : '0;
      end
      check({tag, "_latency"},   32'(last_ready_cyc - a), 32'(exp_lat));
      check({tag, "_velocity"},  32'(bus.velocity),       32'(exp_v));
      check({tag, "_terr"},      32'(bus.timeout_err),    32'(exp_te));
      check({tag, "_starts"},    32'(start_cnt - s0),     32'(2 * 4));
      check({tag, "_resets"},    32'(reset_cnt - r0),     32'd2);
      check({tag, "_readies"},   32'(ready_cnt - y0),     32'd1);
   endtask

   initial begin
      n_checks = 0; n_err = 0;
      start_cnt = 0; reset_cnt = 0; ready_cnt = 0; last_ready_cyc = -1;
      mvel = 0; mterr = 0;
      fill_idle(0);
      rst_n = 1'b0;
      bus.get_velocity = 1'b0;
      bus.meas_done    = 1'b0;
      bus.meas_dist    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      do_request("avg60",     50,  3, 70,  3, 1'b0, -1, 19, 3, 0);
      do_request("avg200",   150,  3, 250, 3, 1'b0, -1, 19, 1, 0);
      do_request("avg99",     99,  3, 100, 3, 1'b0, -1, 19, 3, 0);
      do_request("avg300",   300,  3, 300, 3, 1'b0, -1, 19, 0, 0);
      do_request("timeout",    0,  0, 100, 3, 1'b0, -1, 36, 0, 1);
      do_request("coincide", 120, 20, 120, 3, 1'b0, -1, 36, 2, 0);
      do_request("clear_te", 120,  3, 120, 3, 1'b0, -1, 19, 2, 0);
      repeat (3) @(negedge clk);
      do_request("abort",     50,  3, 70,  3, 1'b0, 11, 0, 0, 0);
      do_request("restart",  200,  3, 220, 3, 1'b1, -1, 19, 1, 0);
      do_request("b2b",       10,  3, 30,  3, 1'b0, -1, 19, 3, 0);
      repeat (5) @(negedge clk);
      check("hold_velocity", 32'(bus.velocity), 32'd3);

      #2;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
